// File: rtl/alu_muldiv.sv
// Purpose : EX-stage ALU with branch compare and a sequential mult/div unit with HI/LO registers.
// Latency : ALU result, zero and overflow are combinational; mult/div writes hi/lo WIDTH+1 cycles after md_start.
// Backpr. : no handshake; busy stays high while mult/div runs and a md_start seen while busy is dropped.
//
// Optional feature: define ALU_OVERFLOW_EN to build signed add/sub overflow
// detection; when it is undefined, overflow is tied to 0.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   r1, r2              operands (r1[SHW-1:0] is the shift amount, r2 the shifted value)
//   controle            ALU operation select
//   branch_eq/neq       BEQ / BNE compare enables, branch_eq has priority
//   md_start, md_op     start mult/div: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rst, zero, overflow combinational ALU result, branch-taken flag, signed overflow
//   busy, done          mult/div in progress, one-cycle pulse when hi/lo update
//   hi, lo              HI/LO registers
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [3:0]       controle,
  input  logic             branch_eq,
  input  logic             branch_neq,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic [WIDTH-1:0] rst,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic             w_sltu;

  assign w_sum  = r1 + r2;
  assign w_diff = r1 - r2;
  assign w_slt  = $signed(r1) < $signed(r2);
  assign w_sltu = r1 < r2;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_comb begin
    rst = '0;
    case (controle)
      4'b0000: rst = r1 & r2;
      4'b0001: rst = r1 | r2;
      4'b0010: rst = w_sum;
      4'b0110: rst = w_diff;
      4'b0111: rst = {{(WIDTH-1){1'b0}}, w_slt};
      4'b1000: rst = {{(WIDTH-1){1'b0}}, w_sltu};
      4'b1100: rst = ~(r1 | r2);
      4'b0011: rst = r1 ^ r2;
      4'b0100: rst = r2 << r1[SHW-1:0];
      4'b0101: rst = r2 >> r1[SHW-1:0];
      4'b1001: rst = $unsigned($signed(r2) >>> r1[SHW-1:0]);
      4'b1101: rst = r_hi;
      4'b1110: rst = r_lo;
      default: rst = '0;
    endcase
  end

  always_comb begin
    zero = 1'b0;
    if (branch_eq) begin
      zero = (r1 == r2);
    end else if (branch_neq) begin
      zero = (r1 != r2);
    end
  end

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: operands effectively of equal sign, result sign differs.
  always_comb begin
    overflow = 1'b0;
    if (controle == 4'b0010) begin
      overflow = (r1[WIDTH-1] == r2[WIDTH-1]) && (w_sum[WIDTH-1] != r1[WIDTH-1]);
    end else if (controle == 4'b0110) begin
      overflow = (r1[WIDTH-1] != r2[WIDTH-1]) && (w_diff[WIDTH-1] != r1[WIDTH-1]);
    end
  end
`else
  assign overflow = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Mult/div FSM
  // ---------------------------------------------------------------------------
  state_t         r_state;
  state_t         w_next;
  logic [SHW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (md_start) w_next = S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Mult/div datapath
  //   multiply: {r_acc, r_q} is the product/multiplier shift pair, r_b the multiplicand
  //   divide:   r_acc is the partial remainder, r_q the dividend/quotient, r_b the divisor
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_a_orig;
  logic [1:0]       r_op;
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_done;

  logic             w_signed;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_signed = ~md_op[0];
  assign w_neg_a  = w_signed & r1[WIDTH-1];
  assign w_neg_b  = w_signed & r2[WIDTH-1];
  // Most-negative input maps to 2^(WIDTH-1), which is correct read as unsigned.
  assign w_mag_a  = w_neg_a ? -r1 : r1;
  assign w_mag_b  = w_neg_b ? -r2 : r2;

  // Carry out of the add is shifted back into the product on the same step.
  assign w_add   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  // Partial remainder stays below the divisor, so bit WIDTH is the borrow.
  assign w_trial = {r_acc, r_q[WIDTH-1]} - {1'b0, r_b};

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_a_orig <= '0;
      r_op     <= 2'b00;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (md_start) begin
            r_op     <= md_op;
            r_a_orig <= r1;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_cnt    <= '0;
            r_acc    <= '0;
            if (md_op[1]) begin
              r_q <= w_mag_a;
              r_b <= w_mag_b;
            end else begin
              r_q <= w_mag_b;
              r_b <= w_mag_a;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[1]) begin
            if (!w_trial[WIDTH]) begin
              r_acc <= w_trial[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
              r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            {r_acc, r_q} <= {w_add, r_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (!r_op[1]) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else if (r_b == '0) begin
            // Divide by zero: all-ones quotient, dividend passed through as remainder.
            r_lo <= '1;
            r_hi <= r_a_orig;
          end else begin
            r_lo <= (r_neg_a ^ r_neg_b) ? -r_q : r_q;
            r_hi <= r_neg_a ? -r_acc : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle MIPS ALU.
- Keeps the combinational ALU result and branch-zero path, generalised to WIDTH bits, and adds XOR, shifts, signed and unsigned SLT.
- Adds a sequential multiply/divide unit (one bit per cycle) with HI/LO registers for MULT/MULTU/DIV/DIVU/MFHI/MFLO.
- Sits in the EX stage; the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, datapath width; even, >=8.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- r1  input  WIDTH  operand A; for shifts, r1[SHW-1:0] is the shift amount.
- r2  input  WIDTH  operand B; for shifts, the value shifted.
- controle  input  4  ALU operation select.
- branch_eq  input  1  BEQ compare enable.
- branch_neq  input  1  BNE compare enable.
- md_start  input  1  start a mult/div on this cycle.
- md_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rst  output  WIDTH  ALU result (combinational).
- zero  output  1  branch-taken flag (combinational).
- overflow  output  1  signed add/sub overflow (see optional feature).
- busy  output  1  mult/div in progress.
- done  output  1  one-cycle pulse when hi/lo are updated.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE. rst, zero and overflow are combinational and have no reset value.
- zero:
  - branch_eq=1 -> r1==r2.
  - else branch_neq=1 -> r1!=r2.
  - else 0.
  - branch_eq has priority when both are high.
- controle -> rst, all results WIDTH bits, wrap-around arithmetic:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 SLT, signed, zero-extended 0/1.
  - 1000 SLTU, unsigned.
  - 1100 NOR; 0011 XOR.
  - 0100 SLL r2<<r1[SHW-1:0]; 0101 SRL, logical; 1001 SRA, arithmetic.
  - 1101 rst=hi (MFHI); 1110 rst=lo (MFLO).
  - Any other code -> 0.
- Mult/div FSM states: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
- Start:
  - md_start=1 in IDLE captures r1, r2 and md_op at that edge and enters RUN.
  - busy=1 from the following cycle through FIX.
  - md_start while busy is ignored; the operands are not captured.
- RUN:
  - Signed ops work on operand magnitudes.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
- FIX:
  - Applies sign correction.
  - MULT: product sign = sign(A) XOR sign(B).
  - DIV: quotient sign = sign(A) XOR sign(B); remainder takes the sign of the dividend.
- Exit from FIX (the edge back to IDLE):
  - Multiply: hi = upper WIDTH bits of the 2*WIDTH product, lo = lower WIDTH bits.
  - Divide: lo = quotient, hi = remainder.
  - busy -> 0 and done = 1 for exactly one cycle.
- Total latency: start edge to hi/lo-valid edge = WIDTH+1 cycles.
- Divide by zero: no exception; lo = all ones, hi = dividend (r1 as captured). Same latency as a normal divide.
- DIV of most-negative by -1: lo = most-negative, hi = 0; no trap.
- hi/lo hold their values at all other times; the combinational ALU path stays usable while busy.
- MFHI/MFLO issued while busy return the old hi/lo; interlock is the control unit's job.
- reset mid-operation: FSM -> IDLE, hi/lo -> 0, no done pulse.
- md_start in the same cycle that done is high: accepted, because the FSM is already in IDLE.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined: overflow = 1 when controle is 0010 and signed A+B overflows, or controle is 0110 and signed A-B overflows. rst still carries the wrapped result.
- Undefined: overflow tied to 0; no overflow logic synthesised.

Test Plan:
- WIDTH=32, controle=0110, r1=5, r2=7 -> rst=0xFFFFFFFE. controle=0111 -> rst=1. controle=1000, r1=0xFFFFFFFF, r2=1 -> rst=0.
- controle=1001, r1=4, r2=0x80000000 -> rst=0xF8000000. controle=0101 with the same operands -> rst=0x08000000. branch_eq=1 and branch_neq=1, r1=r2=3 -> zero=1.
- MULT r1=-3, r2=7, md_start one cycle:
  - busy high for 33 cycles, then done pulses.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - controle=1110 then gives rst=0xFFFFFFEB.
- DIV r1=-7, r2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU r1=9, r2=0 -> lo=0xFFFFFFFF, hi=9.
- Start MULTU 0xFFFFFFFF*0xFFFFFFFF, then reset at cycle 10 -> busy=0, hi=lo=0, no done pulse. A second md_start during busy changes nothing.
- With ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 -> overflow=1, rst=0x80000000. Without it -> overflow=0.
